// File: rtl/wb_uart_master.sv
// UART-command-to-Wishbone bridge. A command byte (A5 write / 5A read),
// a 4-byte address and, for writes, 4 data bytes start one pipelined
// Wishbone transaction. The result is returned as a status header,
// followed by 4 data bytes after a successful read.
module wb_uart_master #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_stall_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WR   = 8'hA5;
  localparam logic [7:0] CMD_RD   = 8'h5A;
  localparam logic [7:0] RSP_WACK = 8'h57;
  localparam logic [7:0] RSP_RACK = 8'h52;
  localparam logic [7:0] RSP_ERR  = 8'hEE;
  localparam logic [7:0] RSP_UNK  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP_HDR, RESP_DATA
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      bcnt;      // byte index within address/data/response word
  logic            is_wr;     // current command is a write
  logic            rd_resp;   // header is followed by 4 read-data bytes
  logic [TW-1:0]   tcnt;      // cycles spent in BUS_REQ/BUS_WAIT
  logic [31:0]     rdata;     // captured read data, shifted out MSB-first

  logic            rx_fire, tx_fire, is_cmd;
  logic            bus_resp, bus_to, bus_end, bus_fail;
  logic [7:0]      hdr;

  assign rx_ready_o = (state == IDLE) || (state == ADDR) || (state == DATA);
  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign tx_fire    = tx_valid_o & tx_ready_i;
  assign is_cmd     = (rx_data_i == CMD_WR) || (rx_data_i == CMD_RD);

  // A response only counts once the request has actually been issued:
  // either in the non-stalled BUS_REQ cycle or any BUS_WAIT cycle.
  assign bus_resp = ((state == BUS_REQ && !wbm_stall_i) || state == BUS_WAIT)
                    && (wbm_ack_i || wbm_err_i);
  assign bus_to   = ((state == BUS_REQ) || (state == BUS_WAIT)) && !bus_resp
                    && (tcnt == TO_LAST);
  assign bus_end  = bus_resp | bus_to;
  assign bus_fail = bus_to | (bus_resp & wbm_err_i);
  assign hdr      = bus_fail ? RSP_ERR : (is_wr ? RSP_WACK : RSP_RACK);

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (rx_fire) state_nx = is_cmd ? ADDR : RESP_HDR;
      ADDR:      if (rx_fire && bcnt == 2'd3) state_nx = is_wr ? DATA : BUS_REQ;
      DATA:      if (rx_fire && bcnt == 2'd3) state_nx = BUS_REQ;
      BUS_REQ:   if (bus_end) state_nx = RESP_HDR;
                 else if (!wbm_stall_i) state_nx = BUS_WAIT;
      BUS_WAIT:  if (bus_end) state_nx = RESP_HDR;
      RESP_HDR:  if (tx_fire) state_nx = rd_resp ? RESP_DATA : IDLE;
      RESP_DATA: if (tx_fire && bcnt == 2'd3) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Datapath and registered bus/tx outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bcnt       <= '0;
      is_wr      <= 1'b0;
      rd_resp    <= 1'b0;
      tcnt       <= '0;
      rdata      <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_we_o   <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_sel_o  <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
    end else begin
      case (state)
        IDLE: if (rx_fire) begin
          bcnt  <= '0;
          is_wr <= (rx_data_i == CMD_WR);
          if (!is_cmd) begin
            tx_valid_o <= 1'b1;
            tx_data_o  <= RSP_UNK;
            rd_resp    <= 1'b0;
          end
        end
        ADDR: if (rx_fire) begin
          wbm_adr_o <= {wbm_adr_o[23:0], rx_data_i};
          bcnt      <= bcnt + 2'd1;
          if (bcnt == 2'd3 && !is_wr) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'hF;
            tcnt      <= '0;
          end
        end
        DATA: if (rx_fire) begin
          wbm_dat_o <= {wbm_dat_o[23:0], rx_data_i};
          bcnt      <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_sel_o <= 4'hF;
            tcnt      <= '0;
          end
        end
        BUS_REQ, BUS_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (state == BUS_REQ && !wbm_stall_i) wbm_stb_o <= 1'b0;
          if (bus_resp && !wbm_err_i) rdata <= wbm_dat_i;
          if (bus_end) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            tx_valid_o <= 1'b1;
            tx_data_o  <= hdr;
            rd_resp    <= !bus_fail && !is_wr;
          end
        end
        RESP_HDR: if (tx_fire) begin
          if (rd_resp) begin
            tx_data_o <= rdata[31:24];
            rdata     <= {rdata[23:0], 8'h00};
            bcnt      <= '0;
          end else begin
            tx_valid_o <= 1'b0;
          end
        end
        RESP_DATA: if (tx_fire) begin
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            tx_valid_o <= 1'b0;
          end else begin
            tx_data_o <= rdata[31:24];
            rdata     <= {rdata[23:0], 8'h00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_master.sv
// Bench for wb_uart_master: directed scenarios plus random transactions,
// checked against a transaction-level model of the expected response.
module tb_wb_uart_master;
  localparam int TO = 16;

  logic        clk, rst;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] adr, dat_o, dat_i;
  logic        we, cyc, stb, ack, err, stall;
  logic [3:0]  sel;

  wb_uart_master #(.TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_sel_o(sel),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_stall_i(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Slave behaviour: stall count, response latency after request, mode
  // (0 ack, 1 err, 2 ack+err, 3 silent), read data.
  int          s_stall = 0, s_lat = 0, s_mode = 0;
  logic [31:0] s_rdata = '0;
  // Bus monitor results.
  int          cyc_len = 0, stb_len = 0, nreq = 0;
  logic [31:0] req_adr, req_dat;
  logic        req_we;
  logic [3:0]  req_sel;

  // Slave model and bus monitor share a block so the monitor sees this
  // cycle's stall value.
  initial begin
    int sc, w;
    bit reqd;
    stall = 0; ack = 0; err = 0; dat_i = '0;
    sc = 0; w = 0; reqd = 0;
    forever begin
      @(negedge clk);
      ack = 0; err = 0; dat_i = $urandom;
      if (!cyc) begin
        stall = 0; sc = 0; w = 0; reqd = 0;
      end else begin
        if (!reqd) begin
          if (sc < s_stall) begin stall = 1; sc++; end
          else begin stall = 0; reqd = 1; w = 0; end
        end else begin
          stall = 0; w++;
        end
        if (reqd && w == s_lat && s_mode != 3) begin
          ack = (s_mode != 1); err = (s_mode != 0); dat_i = s_rdata;
        end
        cyc_len++;
        if (stb) stb_len++;
        if (stb && !stall) begin
          nreq++; req_adr = adr; req_dat = dat_o; req_we = we; req_sel = sel;
        end
      end
    end
  end

  // Transmit sink: collects accepted bytes and watches hold stability.
  logic [7:0] txq[$];
  int         tx_low = 0, stab_err = 0;
  bit         rand_rdy = 0;
  initial begin
    logic pv, pr;
    logic [7:0] pd;
    pv = 0; pr = 0; pd = '0;
    tx_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; tx_ready = 0;
      end else begin
        if (pv && !pr && (!tx_valid || tx_data != pd)) stab_err++;
        if (tx_low > 0 && tx_valid) begin tx_ready = 0; tx_low--; end
        else tx_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        pv = tx_valid; pr = tx_ready; pd = tx_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    gap = rand_rdy ? $urandom_range(0, 2) : 0;
    repeat (gap) begin @(negedge clk); rx_valid = 0; end
    @(negedge clk);
    rx_data = b; rx_valid = 1;
    while (!rx_ready) @(negedge clk);
  endtask

  task automatic clear_mon();
    cyc_len = 0; stb_len = 0; nreq = 0; stab_err = 0;
    txq.delete();
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] a, d,
                         input int st, lat, mode, input logic [31:0] rd,
                         input string tag);
    logic [7:0] exp[$];
    logic [31:0] got;
    bit wr, known, tmo;
    int k, e_cyc, e_stb, e_req;
    // Expected outcome from the protocol rules.
    wr = (cmd == 8'hA5);
    known = wr || (cmd == 8'h5A);
    k = st + lat;
    tmo = (mode == 3) || (k >= TO);
    if (!known) begin
      exp.push_back(8'h3F); e_cyc = 0; e_stb = 0; e_req = 0;
    end else begin
      e_req = (st < TO) ? 1 : 0;
      e_cyc = tmo ? TO : k + 1;
      e_stb = (st + 1 < e_cyc) ? st + 1 : e_cyc;
      if (tmo || mode == 1 || mode == 2) exp.push_back(8'hEE);
      else if (wr) exp.push_back(8'h57);
      else begin
        exp.push_back(8'h52);
        for (int i = 3; i >= 0; i--) exp.push_back(rd[8*i +: 8]);
      end
    end

    s_stall = st; s_lat = lat; s_mode = mode; s_rdata = rd;
    clear_mon();
    send_byte(cmd);
    if (known) begin
      for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
      if (wr) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    end
    // Keep offering junk while the block is busy; it must be ignored.
    @(negedge clk);
    rx_data = 8'($urandom); rx_valid = 1;
    for (int i = 0; i < 400 && txq.size() < exp.size(); i++) @(negedge clk);
    rx_valid = 0;
    repeat (4) @(negedge clk);

    chk({tag, "_ntx"}, txq.size(), exp.size());
    foreach (exp[i]) begin
      got = (i < txq.size()) ? 32'(txq[i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_tx%0d", tag, i), got, 32'(exp[i]));
    end
    chk({tag, "_nreq"}, nreq, e_req);
    chk({tag, "_cyclen"}, cyc_len, e_cyc);
    chk({tag, "_stblen"}, stb_len, e_stb);
    chk({tag, "_stable"}, stab_err, 0);
    if (e_req != 0) begin
      chk({tag, "_adr"}, req_adr, a);
      chk({tag, "_we"}, 32'(req_we), 32'(wr));
      chk({tag, "_sel"}, 32'(req_sel), 32'hF);
      if (wr) chk({tag, "_dat"}, req_dat, d);
    end
  endtask

  initial begin
    logic [7:0] c;
    int r;
    rst = 0; rx_data = '0; rx_valid = 0;
    #1 rst = 1;
    #1;
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_sel", 32'(sel), 0);
    chk("rst_adr", adr, 0);
    chk("rst_dat", dat_o, 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    repeat (3) @(negedge clk);
    rst = 0;

    run_txn(8'hA5, 32'h0100_0010, 32'hDEAD_BEEF, 0, 2, 0, 0, "wr");
    run_txn(8'h5A, 32'h0000_0004, 0, 3, 0, 0, 32'h1234_5678, "rd");
    run_txn(8'h5A, 32'hFFFF_0000, 0, 0, 0, 3, 0, "tmo");
    run_txn(8'hA5, 32'h0000_0020, 32'h0000_55AA, 0, 1, 2, 0, "errack");
    run_txn(8'h00, 0, 0, 0, 0, 0, 0, "unk");
    tx_low = 10;
    run_txn(8'h5A, 32'h0000_0100, 0, 1, 1, 0, 32'hA1B2_C3D4, "rdhold");
    run_txn(8'hA5, 32'h0000_0200, 32'h1111_2222, 9, 6, 0, 0, "edge15");
    run_txn(8'hA5, 32'h0000_0300, 32'h3333_4444, 10, 6, 0, 0, "edge16");

    // Reset while the read waits for a response.
    s_stall = 0; s_lat = 0; s_mode = 3;
    clear_mon();
    send_byte(8'h5A);
    for (int i = 3; i >= 0; i--) send_byte(8'h40);
    @(negedge clk); rx_valid = 0;
    for (int i = 0; i < 50 && !(cyc && !stb); i++) @(negedge clk);
    chk("rst_in_wait", 32'(cyc && !stb), 1);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("rstw_cyc", 32'(cyc), 0);
    chk("rstw_stb", 32'(stb), 0);
    chk("rstw_tx_valid", 32'(tx_valid), 0);
    repeat (3) @(negedge clk);
    clear_mon();
    rst = 0;
    #1 chk("rstw_rx_ready", 32'(rx_ready), 1);
    repeat (20) @(negedge clk);
    chk("rstw_no_tx", txq.size(), 0);
    chk("rstw_no_cyc", cyc_len, 0);
    run_txn(8'hA5, 32'hCAFE_0000, 32'h0BAD_F00D, 1, 1, 0, 0, "postrst");

    // Randomized traffic with random back-pressure.
    rand_rdy = 1;
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(0, 9);
      c = (r < 4) ? 8'hA5 : (r < 8) ? 8'h5A : 8'($urandom);
      run_txn(c, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 3), $urandom, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_uart_master.md
WB_UART_MASTER -- requirements
Module: wb_uart_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum wb_clk_i cycles from first stb assertion to ack/err before the transaction is aborted.
REQ-002 wb_clk_i  input  1  sole clock; all logic rising-edge.
REQ-003 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 rx_data_i  input  8  command byte from UART receiver.
REQ-005 rx_valid_i  input  1  rx_data_i valid; byte consumed when rx_valid_i & rx_ready_o.
REQ-006 rx_ready_o  output  1  block can accept a command byte.
REQ-007 tx_data_o  output  8  response byte to UART transmitter.
REQ-008 tx_valid_o  output  1  tx_data_o valid; byte consumed when tx_valid_o & tx_ready_i.
REQ-009 tx_ready_i  input  1  transmitter accepts byte.
REQ-010 wbm_adr_o, wbm_dat_o  output  32 each  Wishbone master address / write data.
REQ-011 wbm_dat_i  input  32  Wishbone read data.
REQ-012 wbm_we_o, wbm_cyc_o, wbm_stb_o  output  1 each; wbm_sel_o  output  4.
REQ-013 wbm_ack_i, wbm_err_i, wbm_stall_i  input  1 each  Wishbone pipelined slave responses.

Function
REQ-014 States: IDLE, ADDR, DATA, BUS_REQ, BUS_WAIT, RESP_HDR, RESP_DATA; rx_ready_o=1 only in IDLE/ADDR/DATA.
REQ-015 IDLE: byte 0xA5 -> write, 0x5A -> read, both go to ADDR with byte counter=0; any other byte -> RESP_HDR with response 0x3F.
REQ-016 ADDR: collects 4 bytes MSB-first into wbm_adr_o; after 4th: write -> DATA, read -> BUS_REQ.
REQ-017 DATA: collects 4 bytes MSB-first into wbm_dat_o; after 4th -> BUS_REQ.
REQ-018 BUS_REQ entered cycle N+1 after last byte accepted at N; wbm_cyc_o=wbm_stb_o=1, wbm_sel_o=4'hF, wbm_we_o=1 for write/0 for read, all registered.
REQ-019 wbm_stb_o held while wbm_stall_i=1; cycle with stb=1 and stall=0 is the request; next cycle stb=0, cyc=1, state BUS_WAIT.
REQ-020 ack/err in same cycle as the request (or any BUS_WAIT cycle) terminates transaction; cyc and stb both 0 the following cycle.
REQ-021 ack and err simultaneous: err wins.
REQ-022 Timeout counter cleared on entering BUS_REQ, increments each cycle in BUS_REQ/BUS_WAIT; reaching TIMEOUT_CYCLES without ack/err -> cyc=stb=0 next cycle, treated as err.
REQ-023 Response header: write ack 0x57, read ack 0x52, err/timeout 0xEE; presented in RESP_HDR the cycle after termination.
REQ-024 On read ack, wbm_dat_i captured on the ack cycle; after header accepted, RESP_DATA sends 4 bytes MSB-first, then IDLE.
REQ-025 tx_valid_o/tx_data_o held stable until tx_ready_i; after last byte accepted, tx_valid_o=0 next cycle, state IDLE.
REQ-026 Header 0x57, 0xEE, 0x3F are single-byte responses: after acceptance -> IDLE.
REQ-027 wbm_cyc_o never asserted outside BUS_REQ/BUS_WAIT; at most one outstanding transaction.
REQ-028 rx_valid_i while rx_ready_o=0 is ignored (byte dropped, no state change).

Reset
REQ-029 wb_rst_i asserted: immediately state IDLE, byte counter 0, timeout counter 0, wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=wbm_dat_o=0, tx_valid_o=0, tx_data_o=0.
REQ-030 Reset mid-transaction or mid-response abandons it with no further bus or tx activity; rx_ready_o=1 first cycle after deassertion.

Verification
REQ-031 Write: A5 01 00 00 10 DE AD BE EF, slave acks 2 cycles later -> one cycle adr=0x01000010 dat=0xDEADBEEF we=1 sel=F, tx 0x57.
REQ-032 Read: 5A 00 00 00 04, slave stalls 3 cycles then acks with 0x12345678 -> stb held 4 cycles, tx 52 12 34 56 78.
REQ-033 Timeout: read to unmapped address, no ack, TIMEOUT_CYCLES=16 -> cyc drops after 16 cycles, tx 0xEE only.
REQ-034 Err+ack same cycle on write -> tx 0xEE; unknown command 0x00 -> tx 0x3F, no bus cycle.
REQ-035 tx_ready_i low 10 cycles during read response -> tx_data_o stable, all 5 bytes delivered in order.
REQ-036 Reset asserted in BUS_WAIT -> cyc=0 immediately, no tx byte; subsequent write completes normally.
